// File: rtl/cache_axi_arbiter.sv
// Arbitrates icache/dcache line refills onto one outstanding bridge read burst and
// carries dcache write-backs on a separate path, holding reads that hit an in-flight write line.
module cache_axi_arbiter #(
    parameter int LINE_OFF = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ic_rreq,
    input  logic [31:0] ic_raddr,
    input  logic [7:0]  ic_rlen,
    output logic        ic_rvalid,
    output logic [31:0] ic_rdata,
    output logic        ic_rlast,
    input  logic        dc_rreq,
    input  logic [31:0] dc_raddr,
    input  logic [7:0]  dc_rlen,
    output logic        dc_rvalid,
    output logic [31:0] dc_rdata,
    output logic        dc_rlast,
    input  logic        dc_wreq,
    input  logic [31:0] dc_waddr,
    input  logic [7:0]  dc_wlen,
    input  logic [3:0]  dc_wstrb,
    input  logic [31:0] dc_wdata,
    output logic        dc_wnext,
    output logic        dc_wdone,
    output logic        bus_rreq,
    output logic [31:0] bus_raddr,
    output logic [7:0]  bus_rlen,
    input  logic        bus_rack,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rlast,
    output logic        bus_wreq,
    output logic [31:0] bus_waddr,
    output logic [7:0]  bus_wlen,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_wack,
    input  logic        bus_wnext,
    input  logic        bus_bvalid
);

    typedef enum logic [2:0] {R_IDLE, R_IC_ADDR, R_IC_DATA, R_DC_ADDR, R_DC_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

    rstate_t     rstate_r;
    wstate_t     wstate_r;
    logic        last_rgrant_r;   // 1'b0: icache was granted last, 1'b1: dcache
    logic [7:0]  rbeat_r;
    logic        len_err_r;
    logic        bus_rreq_r;
    logic [31:0] bus_raddr_r;
    logic [7:0]  bus_rlen_r;
    logic [31:0] waddr_r;
    logic [7:0]  wlen_r;
    logic [3:0]  wstrb_r;
    logic [7:0]  wbeat_r;
    logic        bus_wreq_r;
    logic        dc_wdone_r;

    logic        ic_elig_s;
    logic        dc_elig_s;
    logic        grant_dc_s;
    logic        ic_sel_s;
    logic        dc_sel_s;
    logic        wdat_s;

    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
        return a[31:LINE_OFF] == b[31:LINE_OFF];
    endfunction

    assign ic_elig_s  = ic_rreq & ~((wstate_r != W_IDLE) & same_line(ic_raddr, waddr_r));
    assign dc_elig_s  = dc_rreq & ~((wstate_r != W_IDLE) & same_line(dc_raddr, waddr_r));
    assign grant_dc_s = dc_elig_s & (~ic_elig_s | ~last_rgrant_r);

    assign ic_sel_s  = (rstate_r == R_IC_DATA);
    assign dc_sel_s  = (rstate_r == R_DC_DATA);
    assign ic_rvalid = ic_sel_s & bus_rvalid;
    assign ic_rlast  = ic_sel_s & bus_rvalid & bus_rlast;
    assign ic_rdata  = ic_sel_s ? bus_rdata : 32'h0000_0000;
    assign dc_rvalid = dc_sel_s & bus_rvalid;
    assign dc_rlast  = dc_sel_s & bus_rvalid & bus_rlast;
    assign dc_rdata  = dc_sel_s ? bus_rdata : 32'h0000_0000;

    assign wdat_s    = (wstate_r == W_DATA);
    assign dc_wnext  = wdat_s & bus_wnext;
    assign bus_wdata = wdat_s ? dc_wdata : 32'h0000_0000;
    assign dc_wdone  = dc_wdone_r;

    assign bus_rreq  = bus_rreq_r;
    assign bus_raddr = bus_raddr_r;
    assign bus_rlen  = bus_rlen_r;
    assign bus_wreq  = bus_wreq_r;
    assign bus_waddr = waddr_r;
    assign bus_wlen  = wlen_r;
    assign bus_wstrb = wstrb_r;

    // Read FSM: arbitration, address handshake and beat counting
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate_r      <= R_IDLE;
            last_rgrant_r <= 1'b0;
            rbeat_r       <= 8'd0;
            len_err_r     <= 1'b0;
            bus_rreq_r    <= 1'b0;
            bus_raddr_r   <= 32'h0000_0000;
            bus_rlen_r    <= 8'd0;
        end else begin
            case (rstate_r)
                R_IDLE: begin
                    if (ic_elig_s || dc_elig_s) begin
                        bus_rreq_r    <= 1'b1;
                        last_rgrant_r <= grant_dc_s;
                        bus_raddr_r   <= grant_dc_s ? dc_raddr : ic_raddr;
                        bus_rlen_r    <= grant_dc_s ? dc_rlen : ic_rlen;
                        rstate_r      <= grant_dc_s ? R_DC_ADDR : R_IC_ADDR;
                    end
                end
                R_IC_ADDR, R_DC_ADDR: begin
                    if (bus_rack) begin
                        bus_rreq_r <= 1'b0;
                        rbeat_r    <= 8'd0;
                        rstate_r   <= (rstate_r == R_IC_ADDR) ? R_IC_DATA : R_DC_DATA;
                    end
                end
                R_IC_DATA, R_DC_DATA: begin
                    if (bus_rvalid) begin
                        rbeat_r <= rbeat_r + 8'd1;
                        if (bus_rlast) begin
                            // An early or late last beat still closes the burst; only flag it
                            len_err_r <= len_err_r | (rbeat_r != bus_rlen_r);
                            rstate_r  <= R_IDLE;
                        end
                    end
                end
                default: rstate_r <= R_IDLE;
            endcase
        end
    end

    // Write FSM: latch the write-back, count accepted beats, pulse done on response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wstate_r   <= W_IDLE;
            waddr_r    <= 32'h0000_0000;
            wlen_r     <= 8'd0;
            wstrb_r    <= 4'h0;
            wbeat_r    <= 8'd0;
            bus_wreq_r <= 1'b0;
            dc_wdone_r <= 1'b0;
        end else begin
            dc_wdone_r <= 1'b0;
            case (wstate_r)
                W_IDLE: begin
                    // dc_wreq is still high during the done pulse; do not restart on it
                    if (dc_wreq && !dc_wdone_r) begin
                        waddr_r    <= dc_waddr;
                        wlen_r     <= dc_wlen;
                        wstrb_r    <= dc_wstrb;
                        bus_wreq_r <= 1'b1;
                        wstate_r   <= W_ADDR;
                    end
                end
                W_ADDR: begin
                    if (bus_wack) begin
                        bus_wreq_r <= 1'b0;
                        wbeat_r    <= 8'd0;
                        wstate_r   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus_wnext) begin
                        wbeat_r <= wbeat_r + 8'd1;
                        if (wbeat_r == wlen_r) begin
                            wstate_r <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bus_bvalid) begin
                        dc_wdone_r <= 1'b1;
                        wstate_r   <= W_IDLE;
                    end
                end
                default: wstate_r <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: a bridge/cache behavioural model drives the bus side,
// one per-cycle compare process checks routing, write path and RAW ordering.
module tb_cache_axi_arbiter;

    localparam int IC = 1;
    localparam int DC = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ic_rreq, dc_rreq, dc_wreq;
    logic [31:0] ic_raddr, dc_raddr, dc_waddr, dc_wdata;
    logic [7:0]  ic_rlen, dc_rlen, dc_wlen;
    logic [3:0]  dc_wstrb;
    logic        ic_rvalid, ic_rlast, dc_rvalid, dc_rlast, dc_wnext, dc_wdone;
    logic [31:0] ic_rdata, dc_rdata;
    logic        bus_rreq, bus_rack, bus_rvalid, bus_rlast;
    logic [31:0] bus_raddr, bus_rdata, bus_waddr, bus_wdata;
    logic [7:0]  bus_rlen, bus_wlen;
    logic [3:0]  bus_wstrb;
    logic        bus_wreq, bus_wack, bus_wnext, bus_bvalid;

    cache_axi_arbiter #(.LINE_OFF(5)) dut (
        .clk(clk), .resetn(resetn),
        .ic_rreq(ic_rreq), .ic_raddr(ic_raddr), .ic_rlen(ic_rlen),
        .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata), .ic_rlast(ic_rlast),
        .dc_rreq(dc_rreq), .dc_raddr(dc_raddr), .dc_rlen(dc_rlen),
        .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_rlast(dc_rlast),
        .dc_wreq(dc_wreq), .dc_waddr(dc_waddr), .dc_wlen(dc_wlen), .dc_wstrb(dc_wstrb),
        .dc_wdata(dc_wdata), .dc_wnext(dc_wnext), .dc_wdone(dc_wdone),
        .bus_rreq(bus_rreq), .bus_raddr(bus_raddr), .bus_rlen(bus_rlen), .bus_rack(bus_rack),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_rlast(bus_rlast),
        .bus_wreq(bus_wreq), .bus_waddr(bus_waddr), .bus_wlen(bus_wlen), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_wack(bus_wack), .bus_wnext(bus_wnext), .bus_bvalid(bus_bvalid)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;

    // bridge model state
    int rs = 0, nb = 0, r_stop = -1, ws = 0, wb = 0;
    bit r_gap = 1'b0, w_gap = 1'b0;
    logic [31:0] rd_addr = 32'h0, wr_addr = 32'h0;
    logic [7:0]  rd_len = 8'd0, wr_len = 8'd0;

    // observation state
    int ic_beats = 0, dc_beats = 0, ic_last_n = 0, wnext_cnt = 0, wdone_cnt = 0;
    int wdone_cyc = 0, ic_last_cyc = 0, dc_rise_cyc = 0, last_beat_cyc = -1, widx = 0;
    int grants[$];
    logic prev_rreq = 1'b0, prev_wout = 1'b0, prev_bvalid = 1'b0, wseen = 1'b0;
    logic own_ic, own_dc, in_w;
    logic [31:0] prev_waddr = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [26:0] line_of(input logic [31:0] a);
        return a[31:5];
    endfunction

    task automatic drive_beat();
        int stop;
        stop = (r_stop >= 0) ? r_stop : int'(rd_len);
        bus_rvalid = 1'b1;
        bus_rdata  = rd_addr + 32'(nb * 4);
        bus_rlast  = (nb == stop);
    endtask

    // Bridge model: accepts addresses immediately, streams beats, answers writes
    initial forever begin
        @(posedge clk); #1;
        if (!resetn) begin
            rs = 0; ws = 0;
            bus_rack = 1'b0; bus_rvalid = 1'b0; bus_rlast = 1'b0; bus_rdata = 32'h0;
            bus_wack = 1'b0; bus_wnext = 1'b0; bus_bvalid = 1'b0;
        end else begin
            case (rs)
                0: if (bus_rreq) begin
                    bus_rack = 1'b1; rd_addr = bus_raddr; rd_len = bus_rlen; rs = 1;
                end
                1: begin bus_rack = 1'b0; nb = 0; rs = 2; drive_beat(); end
                default: begin
                    if (bus_rvalid && bus_rlast) begin
                        bus_rvalid = 1'b0; bus_rlast = 1'b0; rs = 0;
                    end else begin
                        if (bus_rvalid) nb++;
                        if (r_gap && bus_rvalid) begin
                            bus_rvalid = 1'b0; bus_rlast = 1'b0;
                        end else begin
                            drive_beat();
                        end
                    end
                end
            endcase
            case (ws)
                0: if (bus_wreq) begin
                    bus_wack = 1'b1; wr_addr = bus_waddr; wr_len = bus_wlen; ws = 1;
                end
                1: begin bus_wack = 1'b0; wb = 0; bus_wnext = 1'b1; ws = 2; end
                2: begin
                    if (bus_wnext) wb++;
                    if (wb == int'(wr_len) + 1) begin
                        bus_wnext = 1'b0; ws = 3;
                    end else begin
                        bus_wnext = w_gap ? ~bus_wnext : 1'b1;
                    end
                end
                3: begin bus_bvalid = 1'b1; ws = 4; end
                default: begin bus_bvalid = 1'b0; ws = 0; end
            endcase
        end
    end

    // Dcache write-data model: next beat presented after each consumed beat
    initial forever begin
        @(negedge clk); wseen = dc_wnext;
        @(posedge clk); #1;
        if (wseen) widx++;
        if (!dc_wreq) widx = 0;
        dc_wdata = 32'hD000_0000 + dc_waddr + 32'(widx);
    end

    // Per-cycle compare against the model
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!resetn) begin
            chk("reset_outputs_zero",
                {ic_rvalid, ic_rlast, dc_rvalid, dc_rlast, dc_wnext, dc_wdone, bus_rreq, bus_wreq,
                 ic_rdata | dc_rdata | bus_wdata | bus_raddr | bus_waddr},
                64'h0);
            prev_rreq = 1'b0; prev_wout = 1'b0; prev_bvalid = 1'b0; last_beat_cyc = -1;
        end else begin
            own_ic = bus_rvalid && (rs == 2) && (rd_addr == ic_raddr);
            own_dc = bus_rvalid && (rs == 2) && (rd_addr != ic_raddr);
            chk("ic_route", {ic_rvalid, ic_rlast}, {own_ic, own_ic & bus_rlast});
            chk("dc_route", {dc_rvalid, dc_rlast}, {own_dc, own_dc & bus_rlast});
            if (own_ic) chk("ic_data", ic_rdata, bus_rdata);
            if (own_dc) chk("dc_data", dc_rdata, bus_rdata);
            in_w = (ws == 2);
            chk("wnext", dc_wnext, in_w & bus_wnext);
            chk("wdata", bus_wdata, in_w ? dc_wdata : 32'h0);
            chk("wdone", dc_wdone, prev_bvalid);
            if (ic_rvalid) begin
                ic_beats++;
                if (ic_rlast) begin ic_last_n = ic_beats; ic_last_cyc = cyc; last_beat_cyc = cyc; end
            end
            if (dc_rvalid) begin
                dc_beats++;
                if (dc_rlast) last_beat_cyc = cyc;
            end
            if (dc_wnext) wnext_cnt++;
            if (dc_wdone) begin wdone_cnt++; wdone_cyc = cyc; end
            if (bus_rreq && !prev_rreq) begin
                if (bus_raddr == ic_raddr) grants.push_back(IC);
                else if (bus_raddr == dc_raddr) grants.push_back(DC);
                else grants.push_back(0);
                if (bus_raddr == dc_raddr) dc_rise_cyc = cyc;
                if (last_beat_cyc >= 0) chk("b2b_gap_ge2", 64'((cyc - last_beat_cyc) >= 2), 64'h1);
                if (prev_wout) chk("raw_guard", 64'(line_of(bus_raddr) == line_of(prev_waddr)), 64'h0);
            end
            prev_rreq   = bus_rreq;
            prev_wout   = bus_wreq || (ws != 0);
            prev_waddr  = (ws != 0) ? wr_addr : bus_waddr;
            prev_bvalid = bus_bvalid;
        end
    end

    task automatic ic_read(input logic [31:0] a, input logic [7:0] l);
        int t;
        ic_raddr = a; ic_rlen = l; ic_rreq = 1'b1;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (ic_rvalid && ic_rlast) break;
        end
        chk("ic_read_completes", 64'(t < 300), 64'h1);
        @(posedge clk); #1;
        ic_rreq = 1'b0;
    endtask

    task automatic dc_read(input logic [31:0] a, input logic [7:0] l);
        int t;
        dc_raddr = a; dc_rlen = l; dc_rreq = 1'b1;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (dc_rvalid && dc_rlast) break;
        end
        chk("dc_read_completes", 64'(t < 300), 64'h1);
        @(posedge clk); #1;
        dc_rreq = 1'b0;
    endtask

    task automatic dc_write(input logic [31:0] a, input logic [7:0] l);
        int t;
        dc_waddr = a; dc_wlen = l; dc_wstrb = 4'hF; dc_wreq = 1'b1;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (dc_wdone) break;
        end
        chk("dc_write_completes", 64'(t < 300), 64'h1);
        @(posedge clk); #1;
        dc_wreq = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int g0, t;
        resetn = 1'b0;
        ic_rreq = 1'b0; dc_rreq = 1'b0; dc_wreq = 1'b0;
        ic_raddr = 32'h0000_0100; dc_raddr = 32'h0000_0200; dc_waddr = 32'h0;
        ic_rlen = 8'd0; dc_rlen = 8'd0; dc_wlen = 8'd0; dc_wstrb = 4'h0; dc_wdata = 32'h0;
        bus_rack = 1'b0; bus_rvalid = 1'b0; bus_rlast = 1'b0; bus_rdata = 32'h0;
        bus_wack = 1'b0; bus_wnext = 1'b0; bus_bvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_len_err", dut.len_err_r, 64'h0);
        chk("reset_bus_rreq_wreq", {bus_rreq, bus_wreq, bus_rlen, bus_wlen, bus_wstrb}, 64'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // icache-only refill: one-cycle request latency, 8 beats, no dcache traffic
        ic_beats = 0; dc_beats = 0;
        fork ic_read(32'h1FC0_0000, 8'd7); join_none
        @(negedge clk);
        chk("t1_rreq_not_yet", bus_rreq, 64'h0);
        @(negedge clk);
        chk("t1_rreq", bus_rreq, 64'h1);
        chk("t1_raddr", bus_raddr, 64'h1FC0_0000);
        chk("t1_rlen", bus_rlen, 64'h7);
        wait fork;
        @(negedge clk);
        chk("t1_ic_beats", ic_beats, 64'd8);
        chk("t1_rlast_on_beat", ic_last_n, 64'd8);
        chk("t1_dc_beats", dc_beats, 64'd0);
        chk("t1_len_err", dut.len_err_r, 64'h0);

        // simultaneous requests: dcache wins the first tie
        @(posedge clk); #1;
        g0 = grants.size();
        fork
            ic_read(32'h0000_3000, 8'd3);
            dc_read(32'h0000_5000, 8'd3);
        join
        chk("t2_first_dc", grants[g0], DC);
        chk("t2_then_ic", grants[g0 + 1], IC);

        // both held continuously: strict alternation, dropping mid-burst is ignored
        g0 = grants.size();
        ic_raddr = 32'h0000_7000; ic_rlen = 8'd3;
        dc_raddr = 32'h0000_7100; dc_rlen = 8'd3;
        ic_rreq = 1'b1; dc_rreq = 1'b1;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (grants.size() >= g0 + 4) break;
        end
        chk("t2_hold_grants", 64'(t < 300), 64'h1);
        @(posedge clk); #1;
        ic_rreq = 1'b0; dc_rreq = 1'b0;
        repeat (20) @(negedge clk);
        chk("t2_alt0", grants[g0], DC);
        chk("t2_alt1", grants[g0 + 1], IC);
        chk("t2_alt2", grants[g0 + 2], DC);
        chk("t2_alt3", grants[g0 + 3], IC);

        // RAW guard: dcache read to the write-back line waits; icache read proceeds
        @(posedge clk); #1;
        wnext_cnt = 0; wdone_cnt = 0; w_gap = 1'b1;
        g0 = grants.size();
        fork
            dc_write(32'h0000_1040, 8'd7);
            begin
                repeat (2) @(posedge clk);
                #1;
                fork
                    ic_read(32'h0000_2000, 8'd3);
                    dc_read(32'h0000_1050, 8'd3);
                join
            end
        join
        w_gap = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_ic_first", grants[g0], IC);
        chk("t3_dc_after", grants[g0 + 1], DC);
        chk("t3_dc_rreq_cycle_after_wdone", dc_rise_cyc, 64'(wdone_cyc + 1));
        chk("t3_ic_done_before_wdone", 64'(ic_last_cyc < wdone_cyc), 64'h1);
        chk("t3_wnext_count", wnext_cnt, 64'd8);
        chk("t3_wdone_count", wdone_cnt, 64'd1);
        chk("t3_waddr", wr_addr, 64'h0000_1040);
        chk("t3_wlen", wr_len, 64'h7);

        // early last beat: burst closes, len_err set, next request still served
        @(posedge clk); #1;
        ic_beats = 0; dc_beats = 0; r_stop = 3;
        ic_read(32'h1FC0_0040, 8'd7);
        r_stop = -1;
        dc_read(32'h0000_6000, 8'd1);
        @(negedge clk);
        chk("t5_ic_beats", ic_beats, 64'd4);
        chk("t5_len_err", dut.len_err_r, 64'h1);
        chk("t5_next_served", dc_beats, 64'd2);

        // reset during dcache read data and write data phases
        @(posedge clk); #1;
        dc_beats = 0; r_gap = 1'b1; w_gap = 1'b1;
        dc_raddr = 32'h0000_4000; dc_rlen = 8'd7; dc_rreq = 1'b1;
        dc_waddr = 32'h0000_3000; dc_wlen = 8'd7; dc_wstrb = 4'h5; dc_wreq = 1'b1;
        for (t = 0; t < 300; t++) begin
            @(negedge clk);
            if (dc_beats >= 2 && ws == 2) break;
        end
        chk("t6_reached_data_phases", 64'(t < 300), 64'h1);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        chk("t6_read_outs_zero", {ic_rvalid, ic_rlast, dc_rvalid, dc_rlast, bus_rreq, dc_rdata}, 64'h0);
        chk("t6_write_outs_zero", {dc_wnext, dc_wdone, bus_wreq, bus_wstrb, bus_wdata}, 64'h0);
        chk("t6_addr_outs_zero", {bus_raddr, bus_waddr}, 64'h0);
        chk("t6_len_outs_zero", {bus_rlen, bus_wlen}, 64'h0);
        dc_rreq = 1'b0; dc_wreq = 1'b0; r_gap = 1'b0; w_gap = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        chk("t6_len_err_cleared", dut.len_err_r, 64'h0);
        @(posedge clk); #1;
        ic_beats = 0;
        fork ic_read(32'h1FC0_0100, 8'd1); join_none
        @(negedge clk);
        chk("t6_rreq_not_yet", bus_rreq, 64'h0);
        @(negedge clk);
        chk("t6_rreq", bus_rreq, 64'h1);
        chk("t6_raddr", bus_raddr, 64'h1FC0_0100);
        wait fork;
        @(negedge clk);
        chk("t6_ic_beats", ic_beats, 64'd2);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Shares the single cache-side port of the AXI bridge between the instruction cache (line refills) and the data cache (line refills and dirty-line write-backs). Reads from both caches are arbitrated onto one outstanding read burst; data-cache writes have a dedicated write path. A read-after-write guard holds any read that targets a line whose write-back is still in flight. Sits between the two caches and the AXI bridge in the CPU top level.

## Interface
- LINE_OFF, 5, number of low address bits ignored when comparing read and write line addresses
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- ic_rreq / ic_raddr / ic_rlen  in  1/32/8  icache read request, byte address, AXI length (beats-1); held stable until ic_rlast
- ic_rvalid / ic_rdata / ic_rlast  out  1/32/1  icache return beat, data, last beat
- dc_rreq / dc_raddr / dc_rlen  in  1/32/8  dcache read request; same rules as icache
- dc_rvalid / dc_rdata / dc_rlast  out  1/32/1  dcache return beat
- dc_wreq / dc_waddr / dc_wlen / dc_wstrb  in  1/32/8/4  dcache write-back request; held until dc_wdone
- dc_wdata  in  32  current write beat; advanced by dcache on dc_wnext
- dc_wnext / dc_wdone  out  1/1  beat consumed / write response received
- bus_rreq / bus_raddr / bus_rlen  out  1/32/8  read request to bridge
- bus_rack  in  1  bridge accepted read address
- bus_rvalid / bus_rdata / bus_rlast  in  1/32/1  bridge read beat
- bus_wreq / bus_waddr / bus_wlen / bus_wstrb / bus_wdata  out  1/32/8/4/32  write request and beat data
- bus_wack / bus_wnext / bus_bvalid  in  1/1/1  address accepted / beat accepted / response

## Operation
- Read FSM: R_IDLE, R_IC_ADDR, R_IC_DATA, R_DC_ADDR, R_DC_DATA.
- R_IDLE: eligible requesters are those with req high and not RAW-blocked. One eligible -> grant it. Both eligible -> grant the one not in last_rgrant (1-bit register, reset = icache so dcache wins first tie). Move to R_x_ADDR, register bus_raddr/bus_rlen from the winner, bus_rreq=1, update last_rgrant.
- R_x_ADDR: hold bus_rreq and address until bus_rack; then bus_rreq=0, go to R_x_DATA.
- R_x_DATA: route bus_rvalid/bus_rdata/bus_rlast combinationally to the granted cache only; other cache sees valid/last = 0. On bus_rvalid & bus_rlast -> R_IDLE. 8-bit beat counter increments per beat; a bus_rlast arriving with counter != rlen still ends the burst and sets sticky debug flag len_err (internal).
- RAW guard: read blocked when wstate != W_IDLE and raddr[31:LINE_OFF] == latched waddr[31:LINE_OFF]. Applies to both caches.
- Write FSM: W_IDLE, W_ADDR, W_DATA, W_RESP.
- W_IDLE: dc_wreq -> latch waddr/wlen/wstrb, bus_wreq=1, W_ADDR.
- W_ADDR: on bus_wack -> bus_wreq=0, W_DATA.
- W_DATA: bus_wdata = dc_wdata (combinational); dc_wnext = bus_wnext. Beat counter counts bus_wnext; on beat with count == wlen -> W_RESP.
- W_RESP: on bus_bvalid -> dc_wdone pulses 1 cycle (registered), W_IDLE.
- Read and write FSMs run concurrently; at most one read and one write outstanding.

## Timing
- Reset (resetn low, asynchronous): both FSMs idle, all outputs 0, counters 0, last_rgrant = icache, len_err = 0.
- Request to bus_rreq: 1 cycle (registered in R_IDLE). Return data latency: 0 cycles (pass-through).
- Back-to-back: R_IDLE occupies at least one cycle between bursts; next bus_rreq no earlier than 2 cycles after the previous last beat.
- bus_rack in the same cycle bus_rreq rises is legal; transition takes effect next edge.
- Write completing (W_RESP -> W_IDLE) same cycle a blocked read is evaluated: read remains blocked that cycle, eligible next.
- Requests dropped by a requester mid-burst are ignored; the burst runs to bus_rlast.
- Reset asserted mid-burst: everything returns to reset values immediately; bridge is reset by the same resetn.

## Test plan
- Icache only, raddr 0x1FC0_0000, rlen 7 -> bus_rreq 1 cycle later with same addr/len; 8 beats to icache, ic_rlast on beat 8, dc_rvalid stays 0.
- ic_rreq and dc_rreq rise same cycle -> dcache served first, icache next; repeat with both held -> strict alternation.
- dc_wreq waddr 0x0000_1040 wlen 7, then dc_rreq raddr 0x0000_1050 -> bus_rreq held 0 until cycle after dc_wdone; icache read to 0x0000_2000 proceeds concurrently.
- Write with bus_wnext toggling every other cycle -> exactly 8 dc_wnext pulses, bus_wdata tracks dc_wdata, one dc_wdone pulse after bus_bvalid.
- bus_rlast on beat 4 of rlen 7 -> FSM back to R_IDLE, len_err = 1.
- resetn low during R_DC_DATA and W_DATA -> all outputs 0 same cycle; after release, new icache request served normally.
